// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the programmable clock divider.
package clk_div_pkg;

    localparam int unsigned MIN_DIV = 2;

    // Divisors below the minimum are stored as the minimum.
    function automatic logic [31:0] clamp_div(input logic [31:0] d);
        return (d < MIN_DIV) ? 32'(MIN_DIV) : d;
    endfunction

    // ceil(n/2): first count value of the high phase.
    function automatic logic [31:0] half_point(input logic [31:0] n);
        return (n + 32'd1) >> 1;
    endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: counter, shadow divisor, posedge phase flop,
// negedge extension flop for odd ratios, and period-end tick.
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned DEF_DIV = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] div,
    output logic             o_clk,
    output logic             tick,
    output logic [CNT_W-1:0] div_act
);

    logic [CNT_W-1:0] cnt, n, s;
    logic [CNT_W-1:0] cnt_next, n_next, s_next, div_c, half;
    logic             pending, pending_next, idle;
    logic             p, ext, p_next, tick_next, boundary;

    always_comb begin
        div_c        = CNT_W'(clamp_div(32'(div)));
        s_next       = load ? div_c : s;
        pending_next = load | pending;
        n_next       = n;
        // idle marks the first enabled posedge, where a held load is applied
        boundary     = idle || (cnt == n - CNT_W'(1));
        if (boundary) begin
            n_next       = load ? div_c : (pending ? s : n);
            pending_next = 1'b0;
        end
        cnt_next  = (cnt == n - CNT_W'(1)) ? '0 : cnt + CNT_W'(1);
        half      = CNT_W'(half_point(32'(n_next)));
        p_next    = (cnt_next >= half);
        tick_next = (cnt_next == n_next - CNT_W'(1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            n       <= CNT_W'(DEF_DIV);
            s       <= CNT_W'(DEF_DIV);
            pending <= 1'b0;
            idle    <= 1'b1;
            p       <= 1'b0;
            tick    <= 1'b0;
        end else if (!en) begin
            cnt     <= '0;
            p       <= 1'b0;
            tick    <= 1'b0;
            idle    <= 1'b1;
            s       <= s_next;
            pending <= load | pending;
        end else begin
            cnt     <= cnt_next;
            n       <= n_next;
            s       <= s_next;
            pending <= pending_next;
            idle    <= 1'b0;
            p       <= p_next;
            tick    <= tick_next;
        end
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) ext <= 1'b0;
        else     ext <= p & n[0];
    end

    assign o_clk   = p | ext;
    assign div_act = n;

endmodule

// File: rtl/clk_div_prog.sv
// Multi-channel runtime-programmable 50%-duty integer clock divider.
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int unsigned NUM_CH  = 2,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned DEF_DIV = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       en_i,
    input  logic [NUM_CH-1:0]       load_i,
    input  logic [NUM_CH*CNT_W-1:0] div_i,
    output logic [NUM_CH-1:0]       o_clk,
    output logic [NUM_CH-1:0]       tick_o,
    output logic [NUM_CH*CNT_W-1:0] div_act_o
);

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        clk_div_ch #(
            .CNT_W  (CNT_W),
            .DEF_DIV(DEF_DIV)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .en     (en_i[k]),
            .load   (load_i[k]),
            .div    (div_i[k*CNT_W +: CNT_W]),
            .o_clk  (o_clk[k]),
            .tick   (tick_o[k]),
            .div_act(div_act_o[k*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed self-checking bench for clk_div_prog (2 channels, 8-bit, default 3).
module tb_clk_div_prog;

    logic        clk;
    logic        rst;
    logic [1:0]  en_i;
    logic [1:0]  load_i;
    logic [15:0] div_i;
    logic [1:0]  o_clk;
    logic [1:0]  tick_o;
    logic [15:0] div_act_o;

    int n_checks = 0;
    int n_fail   = 0;

    clk_div_prog #(.NUM_CH(2), .CNT_W(8), .DEF_DIV(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .en_i     (en_i),
        .load_i   (load_i),
        .div_i    (div_i),
        .o_clk    (o_clk),
        .tick_o   (tick_o),
        .div_act_o(div_act_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        rst = 1'b1; en_i = 2'b00; load_i = 2'b00; div_i = '0;
        #2;
        n_checks++; if (o_clk !== 2'b00) begin n_fail++; $display("FAIL reset_o_clk got %b want 00", o_clk); end
        n_checks++; if (tick_o !== 2'b00) begin n_fail++; $display("FAIL reset_tick got %b want 00", tick_o); end
        n_checks++; if (div_act_o !== 16'h0303) begin n_fail++; $display("FAIL reset_div_act got %h want 0303", div_act_o); end
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        en_i = 2'b11;
    endtask

    task automatic test_default;
        string ec = "001110001110001110";
        string et = "010010010";
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            for (int c = 0; c < 2; c++) begin
                n_checks++; if (o_clk[c] !== (ec[2*i] == "1")) begin n_fail++; $display("FAIL default_clk ch%0d step %0d got %b want %s", c, i, o_clk[c], ec.substr(2*i, 2*i)); end
                n_checks++; if (tick_o[c] !== (et[i] == "1")) begin n_fail++; $display("FAIL default_tick ch%0d step %0d got %b want %s", c, i, tick_o[c], et.substr(i, i)); end
            end
            @(negedge clk); #1;
            for (int c = 0; c < 2; c++) begin
                n_checks++; if (o_clk[c] !== (ec[2*i+1] == "1")) begin n_fail++; $display("FAIL default_clk_neg ch%0d step %0d got %b want %s", c, i, o_clk[c], ec.substr(2*i+1, 2*i+1)); end
            end
        end
    endtask

    task automatic test_load_mid;
        string ec = "00111000111100001111";
        string et = "0100010001";
        logic [7:0] ea;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            ea = (i < 2) ? 8'd3 : 8'd4;
            n_checks++; if (o_clk[0] !== (ec[2*i] == "1")) begin n_fail++; $display("FAIL load4_clk step %0d got %b want %s", i, o_clk[0], ec.substr(2*i, 2*i)); end
            n_checks++; if (tick_o[0] !== (et[i] == "1")) begin n_fail++; $display("FAIL load4_tick step %0d got %b want %s", i, tick_o[0], et.substr(i, i)); end
            n_checks++; if (div_act_o[7:0] !== ea) begin n_fail++; $display("FAIL load4_act step %0d got %0d want %0d", i, div_act_o[7:0], ea); end
            if (i == 0) begin load_i = 2'b01; div_i[7:0] = 8'd4; end
            if (i == 1) load_i = 2'b00;
            @(negedge clk); #1;
            n_checks++; if (o_clk[0] !== (ec[2*i+1] == "1")) begin n_fail++; $display("FAIL load4_clk_neg step %0d got %b want %s", i, o_clk[0], ec.substr(2*i+1, 2*i+1)); end
        end
    endtask

    task automatic test_load_zero;
        string ec = "00001111001100110011";
        string et = "0001010101";
        logic [7:0] ea;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            ea = (i < 4) ? 8'd4 : 8'd2;
            n_checks++; if (o_clk[0] !== (ec[2*i] == "1")) begin n_fail++; $display("FAIL load0_clk step %0d got %b want %s", i, o_clk[0], ec.substr(2*i, 2*i)); end
            n_checks++; if (tick_o[0] !== (et[i] == "1")) begin n_fail++; $display("FAIL load0_tick step %0d got %b want %s", i, tick_o[0], et.substr(i, i)); end
            n_checks++; if (div_act_o[7:0] !== ea) begin n_fail++; $display("FAIL load0_act step %0d got %0d want %0d", i, div_act_o[7:0], ea); end
            if (i == 0) begin load_i = 2'b01; div_i[7:0] = 8'd0; end
            if (i == 1) load_i = 2'b00;
            @(negedge clk); #1;
            n_checks++; if (o_clk[0] !== (ec[2*i+1] == "1")) begin n_fail++; $display("FAIL load0_clk_neg step %0d got %b want %s", i, o_clk[0], ec.substr(2*i+1, 2*i+1)); end
        end
    endtask

    task automatic test_double_load;
        string ec = "001100000000111111100000";
        string et = "010000001000";
        logic [7:0] ea;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            ea = (i < 2) ? 8'd2 : 8'd7;
            n_checks++; if (o_clk[0] !== (ec[2*i] == "1")) begin n_fail++; $display("FAIL dbl_clk step %0d got %b want %s", i, o_clk[0], ec.substr(2*i, 2*i)); end
            n_checks++; if (tick_o[0] !== (et[i] == "1")) begin n_fail++; $display("FAIL dbl_tick step %0d got %b want %s", i, tick_o[0], et.substr(i, i)); end
            n_checks++; if (div_act_o[7:0] !== ea) begin n_fail++; $display("FAIL dbl_act step %0d got %0d want %0d", i, div_act_o[7:0], ea); end
            if (i == 0) begin load_i = 2'b01; div_i[7:0] = 8'd5; end
            if (i == 1) begin load_i = 2'b01; div_i[7:0] = 8'd7; end
            if (i == 2) load_i = 2'b00;
            @(negedge clk); #1;
            n_checks++; if (o_clk[0] !== (ec[2*i+1] == "1")) begin n_fail++; $display("FAIL dbl_clk_neg step %0d got %b want %s", i, o_clk[0], ec.substr(2*i+1, 2*i+1)); end
        end
    endtask

    task automatic test_enable;
        string ec = "000011100000000011111000";
        string et = "000000000100";
        logic found = 1'b0;
        load_i = 2'b01; div_i[7:0] = 8'd5;
        @(posedge clk); #1;
        load_i = 2'b00;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk); #1;
            found = (div_act_o[7:0] == 8'd5);
        end
        n_checks++;
        if (!found) begin
            n_fail++; $display("FAIL enable_sync div_act got %0d want 5 within 20 cycles", div_act_o[7:0]);
        end else begin
            for (int i = 0; i < 12; i++) begin
                @(posedge clk); #1;
                n_checks++; if (o_clk[0] !== (ec[2*i] == "1")) begin n_fail++; $display("FAIL enable_clk step %0d got %b want %s", i, o_clk[0], ec.substr(2*i, 2*i)); end
                n_checks++; if (tick_o[0] !== (et[i] == "1")) begin n_fail++; $display("FAIL enable_tick step %0d got %b want %s", i, tick_o[0], et.substr(i, i)); end
                if (i == 2) en_i = 2'b10;
                @(negedge clk); #1;
                n_checks++; if (o_clk[0] !== (ec[2*i+1] == "1")) begin n_fail++; $display("FAIL enable_clk_neg step %0d got %b want %s", i, o_clk[0], ec.substr(2*i+1, 2*i+1)); end
                if (i == 5) en_i = 2'b11;
            end
        end
    endtask

    task automatic test_independent;
        logic found = 1'b0;
        int t0 = 0, t1 = 0, h0 = 0, h1 = 0;
        div_i = {8'd9, 8'd6}; load_i = 2'b11;
        @(posedge clk); #1;
        load_i = 2'b00;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk); #1;
            found = (div_act_o == {8'd9, 8'd6});
        end
        n_checks++;
        if (!found) begin
            n_fail++; $display("FAIL indep_sync div_act got %h want 0906 within 40 cycles", div_act_o);
        end
        // 36 cycles spans whole periods of both 6 and 9
        for (int i = 0; i < 36; i++) begin
            @(posedge clk); #1;
            t0 += int'(tick_o[0]); t1 += int'(tick_o[1]);
            h0 += int'(o_clk[0]);  h1 += int'(o_clk[1]);
            @(negedge clk); #1;
            h0 += int'(o_clk[0]);  h1 += int'(o_clk[1]);
        end
        n_checks++; if (t0 != 6)  begin n_fail++; $display("FAIL indep_ticks_ch0 got %0d want 6", t0); end
        n_checks++; if (t1 != 4)  begin n_fail++; $display("FAIL indep_ticks_ch1 got %0d want 4", t1); end
        n_checks++; if (h0 != 36) begin n_fail++; $display("FAIL indep_high_ch0 got %0d want 36", h0); end
        n_checks++; if (h1 != 36) begin n_fail++; $display("FAIL indep_high_ch1 got %0d want 36", h1); end
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk); #1;
            found = o_clk[1];
        end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (o_clk !== 2'b00) begin n_fail++; $display("FAIL midrst_o_clk got %b want 00", o_clk); end
        n_checks++; if (tick_o !== 2'b00) begin n_fail++; $display("FAIL midrst_tick got %b want 00", tick_o); end
        n_checks++; if (div_act_o !== 16'h0303) begin n_fail++; $display("FAIL midrst_div_act got %h want 0303", div_act_o); end
        @(negedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_default();
        test_load_mid();
        test_load_zero();
        test_double_load();
        test_enable();
        test_independent();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
